univ_shift_reg: RTL

Parametrised universal shift register. Successor to the 4-bit left-only shift register: configurable width, selectable shift/rotate direction, parallel load and synchronous clear. Registered serial-out bit, plus a shift counter with a "full" flag so the block can act as a serialiser or deserialiser front end. Used standalone or wrapped by serial link blocks in the shift_registers area.

---
 rtl/shift_pkg.sv | 17 +
 rtl/shift_cnt.sv | 39 +++
 rtl/univ_shift_reg.sv | 83 ++++++++
 3 files changed

// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - mode encodings and counter sizing for the universal shift register
package shift_pkg;

   localparam logic [2:0] MODE_HOLD  = 3'd0;
   localparam logic [2:0] MODE_SHL   = 3'd1;
   localparam logic [2:0] MODE_SHR   = 3'd2;
   localparam logic [2:0] MODE_ROL   = 3'd3;
   localparam logic [2:0] MODE_ROR   = 3'd4;
   localparam logic [2:0] MODE_LOAD  = 3'd5;
   localparam logic [2:0] MODE_CLEAR = 3'd6;

   // Enough bits to hold the value WIDTH itself, since the counter saturates there.
   function automatic int cnt_width(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/shift_cnt.sv
// rtl/shift_cnt.sv - saturating shift counter with clear and registered full flag
module shift_cnt
   import shift_pkg::*;
#(
   parameter  int WIDTH = 4,
   localparam int CNT_W = cnt_width(WIDTH)
) (
   input  logic             clk,
   input  logic             rset,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt,
   output logic             full
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

   logic [CNT_W-1:0] cnt_nxt;

   always_comb begin
      cnt_nxt = cnt;
      if (clr)
         cnt_nxt = '0;
      else if (inc && (cnt != CNT_MAX))
         cnt_nxt = cnt + CNT_W'(1);
   end

   // full is derived from the next count so it rises on the edge doing the last shift.
   always_ff @(posedge clk or posedge rset) begin
      if (rset) begin
         cnt  <= '0;
         full <= 1'b0;
      end else begin
         cnt  <= cnt_nxt;
         full <= (cnt_nxt == CNT_MAX);
      end
   end

endmodule

// File: rtl/univ_shift_reg.sv
// rtl/univ_shift_reg.sv - universal shift/rotate register with load, clear and shift counter
module univ_shift_reg
   import shift_pkg::*;
#(
   parameter  int               WIDTH   = 4,
   parameter  logic [WIDTH-1:0] RST_VAL = '0,
   localparam int               CNT_W   = cnt_width(WIDTH)
) (
   input  logic             clk,
   input  logic             rset,
   input  logic             en,
   input  logic [2:0]       mode,
   input  logic             x,
   input  logic [WIDTH-1:0] load_data,
   output logic [WIDTH-1:0] out,
   output logic             sout,
   output logic [CNT_W-1:0] cnt,
   output logic             full
);

   logic shift_op;
   logic clr_op;

   always_comb begin
      shift_op = 1'b0;
      clr_op   = 1'b0;
      if (en) begin
         case (mode)
            MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR: shift_op = 1'b1;
            MODE_LOAD, MODE_CLEAR:                  clr_op   = 1'b1;
            default: ;
         endcase
      end
   end

   // HOLD and the reserved encoding fall through to default and keep out/sout.
   always_ff @(posedge clk or posedge rset) begin
      if (rset) begin
         out  <= RST_VAL;
         sout <= 1'b0;
      end else if (en) begin
         case (mode)
            MODE_SHL: begin
               out  <= {out[WIDTH-2:0], x};
               sout <= out[WIDTH-1];
            end
            MODE_SHR: begin
               out  <= {x, out[WIDTH-1:1]};
               sout <= out[0];
            end
            MODE_ROL: begin
               out  <= {out[WIDTH-2:0], out[WIDTH-1]};
               sout <= out[WIDTH-1];
            end
            MODE_ROR: begin
               out  <= {out[0], out[WIDTH-1:1]};
               sout <= out[0];
            end
            MODE_LOAD: begin
               out  <= load_data;
               sout <= 1'b0;
            end
            MODE_CLEAR: begin
               out  <= '0;
               sout <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   shift_cnt #(
      .WIDTH (WIDTH)
   ) u_cnt (
      .clk  (clk),
      .rset (rset),
      .inc  (shift_op),
      .clr  (clr_op),
      .cnt  (cnt),
      .full (full)
   );

endmodule
